// File: rtl/register_file_wb_pkg.sv
// ===========================================================================
// register_file_wb_pkg : shared widths and limits for the write-back regfile
// Rev 1.0
// ===========================================================================
`default_nettype none

package register_file_wb_pkg;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 4;
   localparam int NUM_REGS     = 15;
   localparam int MAX_INFLIGHT = 3;
   localparam int CNT_W        = 2;

   localparam logic [ADDR_W-1:0] PC_IDX    = ADDR_W'(15);
   localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_INFLIGHT);

   // PC is never backed by storage, even if NUM_REGS is retuned upward.
   function automatic logic is_arch(input logic [ADDR_W-1:0] idx);
      return (idx < REG_LIMIT) && (idx != PC_IDX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_wb_sb_counter.sv
// ===========================================================================
// sb_counter : saturating pending-write counter with sticky over/underflow
// Rev 1.0
// ===========================================================================
`default_nettype none

module sb_counter
   import register_file_wb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (inc && !dec) begin
         if (cnt == CNT_MAX) err <= 1'b1;
         else                cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc) begin
         if (cnt == '0) err <= 1'b1;
         else           cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/register_file_wb.sv
// ===========================================================================
// register_file_wb : ARM register file with write-back port and hazard board
// Option macro REGFILE_WB_BYPASS_EN enables same-cycle write-to-read bypass.
// Rev 1.0
// ===========================================================================
`default_nettype none

module register_file_wb
   import register_file_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   input  logic              src2_used,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_dest,
   output logic              hazard1,
   output logic              hazard2,
   output logic              sb_error
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [CNT_W-1:0]    cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] err_vec;
   logic [CNT_W-1:0]    cnt1;
   logic [CNT_W-1:0]    cnt2;
   logic                src1_ok;
   logic                src2_ok;

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
         logic hit_wb;
         logic hit_issue;

         assign hit_wb    = wb_en    && (wb_dest    == ADDR_W'(i));
         assign hit_issue = issue_en && (issue_dest == ADDR_W'(i));

         always_ff @(posedge clk or posedge rst) begin
            if (rst)         regs[i] <= '0;
            else if (hit_wb) regs[i] <= wb_value;
         end

         sb_counter u_sb (
            .clk (clk),
            .rst (rst),
            .inc (hit_issue),
            .dec (hit_wb),
            .cnt (cnt[i]),
            .err (err_vec[i])
         );
      end
   endgenerate

   assign src1_ok  = is_arch(src1);
   assign src2_ok  = is_arch(src2);
   assign sb_error = |err_vec;

`ifdef REGFILE_WB_BYPASS_EN
   logic byp1;
   logic byp2;

   assign byp1 = src1_ok && wb_en && (wb_dest == src1);
   assign byp2 = src2_ok && wb_en && (wb_dest == src2);
`endif

   always_comb begin
      reg1 = '0;
      reg2 = '0;
      cnt1 = '0;
      cnt2 = '0;
      if (src1_ok) begin
         reg1 = regs[src1];
         cnt1 = cnt[src1];
      end
      if (src2_ok) begin
         reg2 = regs[src2];
         cnt2 = cnt[src2];
      end
      hazard1 = (cnt1 != '0);
      hazard2 = src2_used && (cnt2 != '0);
`ifdef REGFILE_WB_BYPASS_EN
      // The write completing this cycle is forwarded, so it no longer blocks ID.
      if (byp1) begin
         reg1 = wb_value;
         if (cnt1 == CNT_W'(1)) hazard1 = 1'b0;
      end
      if (byp2) begin
         reg2 = wb_value;
         if (cnt2 == CNT_W'(1)) hazard2 = 1'b0;
      end
`endif
   end

endmodule

`default_nettype wire

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- Architectural register file for the ARM pipeline; the consuming end of the write-back path.
- Accepts the selected write-back result (ALU or memory) with its destination and enable, and serves two combinational read ports to the ID stage.
- Holds a per-register pending-write scoreboard: issue increments it, write-back decrements it. ID uses the resulting hazard flags to stall.

Parameters:
- NUM_REGS, 15, architectural registers R0..R14; index 15 (PC) is not stored.
- DATA_W, 32, register width.
- ADDR_W, 4, register index width.
- MAX_INFLIGHT, 3, max outstanding writes per register (EX, MEM, WB); counter width is 2 bits.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- src1  in  ADDR_W  read port 1 index.
- src2  in  ADDR_W  read port 2 index.
- src2_used  in  1  qualifies hazard2; 0 means operand 2 is an immediate.
- reg1  out  DATA_W  read data port 1.
- reg2  out  DATA_W  read data port 2.
- wb_en  in  1  write-back enable from WB stage.
- wb_dest  in  ADDR_W  write-back destination.
- wb_value  in  DATA_W  write-back data (WB mux output).
- issue_en  in  1  instruction leaving ID with writeback enabled (not stalled, not flushed).
- issue_dest  in  ADDR_W  destination of the issuing instruction.
- hazard1  out  1  pending write to src1.
- hazard2  out  1  pending write to src2, only when src2_used=1.
- sb_error  out  1  sticky: scoreboard overflow or underflow.

Behaviour:
- Reset (async, rst=1): all registers=0, all counters=0, sb_error=0. With registers at 0, reg1/reg2=0 and hazard1/hazard2=0. Reset mid-operation discards pending counts immediately.
- Write: at rising clk, if wb_en and wb_dest<NUM_REGS, then reg[wb_dest]<=wb_value. Writes to index >=NUM_REGS are ignored.
- Read: combinational. reg1=reg[src1] if src1<NUM_REGS, else 0; reg2 likewise.
- Scoreboard counter cnt[i], 2 bits, updated at rising clk:
  - inc = issue_en && issue_dest==i
  - dec = wb_en && wb_dest==i
  - inc only: cnt+1. dec only: cnt-1. Both: unchanged. Neither: unchanged.
  - Indices >=NUM_REGS have no counter; issue/wb to them is never counted and never raises an error.
- Error detection:
  - inc only while cnt==MAX_INFLIGHT: cnt holds, sb_error<=1.
  - dec only while cnt==0: cnt holds at 0, sb_error<=1.
  - sb_error clears only on reset.
- Hazards: hazard1 = (src1<NUM_REGS) && cnt[src1]!=0; hazard2 = src2_used && (src2<NUM_REGS) && cnt[src2]!=0. Both combinational from the registered counts.
- Latency:
  - A write becomes visible on reg1/reg2 in the cycle after the wb_en edge.
  - Hazard clears in the cycle after the write-back edge.
  - An issue raises the hazard in the cycle after the issue edge.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read bypass: if wb_en && wb_dest==src1 && src1<NUM_REGS, then reg1=wb_value (same for reg2).
  - hazard1 is suppressed when the only pending write to src1 is the one completing now (cnt[src1]==1 and dec for src1); same for hazard2.
- Undefined: reads return stored values only; hazards follow the registered counts as above.

Decomposition:
- Shared package holds DATA_W, ADDR_W, the NUM_REGS and PC index (15) constants, and MAX_INFLIGHT.
- One natural sub-module: sb_counter, a single saturating up/down counter with inc, dec, error out. Instantiated NUM_REGS times.
- Storage array, read muxes, and the error OR-reduction live in the top.

Test Plan:
- Reset → reg1=reg2=0, hazard1=hazard2=0, sb_error=0. Then wb_en=1, wb_dest=3, wb_value=0x0000_00AB for one edge. Next cycle src1=3 → reg1=0x0000_00AB.
- Issue dest=5 at edge 1; src1=5 → hazard1=1 from cycle 2. wb_en, wb_dest=5, value 0x1234_5678 at edge 4 → hazard1=0 and reg1=0x1234_5678 in cycle 5.
- Same edge issue_en dest=7 and wb_en dest=7, with cnt[7]=1 → cnt stays 1, hazard1 (src1=7) stays 1, no error.
- Issue dest=2 four times with no write-back → cnt saturates at 3, sb_error=1 after the 4th edge. wb_en dest=4 with cnt[4]=0 also sets sb_error. Assert rst mid-sequence → sb_error=0 and all hazards 0 asynchronously.
- wb_en dest=15, value 0xFFFF_FFFF; issue dest=15 → no storage change, src1=15 reads 0, hazard1=0, sb_error=0.
- REGFILE_WB_BYPASS_EN defined: cnt[9]=1, wb_en dest=9, value 0xDEAD_BEEF, src2=9, src2_used=1 in the same cycle → reg2=0xDEAD_BEEF and hazard2=0 that cycle. Undefined: reg2=old value and hazard2=1.
